alu_multicycle: RTL and testbench

Parametrised, multi-cycle successor to the combinational ALU control path: it decodes `aluOp`/`funct3`/`funct7_5`, executes the operation on `XLEN`-bit operands and returns a registered result over a valid/ready handshake. Single-cycle ops (add/sub/logic/compare) finish in one cycle. Shifts and multiply are iterative to save area. It sits in the execute stage between the decode/operand-select logic and writeback, and stalls the pipeline through `in_ready`.

---
 rtl/alu_multicycle.sv | 146 ++++++++++++++
 tb/tb_alu_multicycle.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/logic/compare, iterative
// shifts (one bit per cycle) and a shift-add multiplier, behind valid/ready handshakes.
module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shk_t;

  state_t          state;
  shk_t            shk, shk_q;
  logic [SHW:0]    cnt;
  logic [XLEN-1:0] work, mcand, mplier;
  logic [XLEN-1:0] sc_res, shifted, mul_sum;
  logic [SHW-1:0]  shamt;
  logic            sc_ill, is_shift, is_mul;

  assign in_ready = (state == IDLE);
  assign shamt    = op_b[SHW-1:0];

  // Decode of the offered op; shifts default to op_a so shamt 0 completes single-cycle.
  always_comb begin
    sc_res   = '0;
    sc_ill   = 1'b0;
    is_shift = 1'b0;
    is_mul   = 1'b0;
    shk      = SH_LL;
    case (aluOp)
      2'b00: sc_res = op_a + op_b;
      2'b01: sc_res = op_a - op_b;
      2'b10: begin
        case (funct3)
          3'b000: sc_res = funct7_5 ? (op_a - op_b) : (op_a + op_b);
          3'b001: begin is_shift = 1'b1; shk = SH_LL; sc_res = op_a; end
          3'b010: sc_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
          3'b011: sc_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
          3'b100: sc_res = op_a ^ op_b;
          3'b101: begin is_shift = 1'b1; shk = funct7_5 ? SH_RA : SH_RL; sc_res = op_a; end
          3'b110: sc_res = op_a | op_b;
          default: sc_res = op_a & op_b;
        endcase
      end
      default: begin
        if (funct3 == 3'b000) is_mul = 1'b1;
        else sc_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    case (shk_q)
      SH_LL:   shifted = {work[XLEN-2:0], 1'b0};
      SH_RA:   shifted = {work[XLEN-1], work[XLEN-1:1]};
      default: shifted = {1'b0, work[XLEN-1:1]};
    endcase
    mul_sum = mplier[0] ? (work + mcand) : work;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shk_q     <= SH_LL;
      cnt       <= '0;
      work      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              work   <= '0;
              mcand  <= op_a;
              mplier <= op_b;
              cnt    <= (SHW+1)'(XLEN);
              state  <= MUL;
            end else if (is_shift && (shamt != '0)) begin
              work  <= op_a;
              shk_q <= shk;
              cnt   <= {1'b0, shamt};
              state <= SHIFT;
            end else begin
              result    <= sc_res;
              zero      <= (sc_res == '0);
              illegal   <= sc_ill;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 1'b1;
          if (cnt == 1) begin
            result    <= shifted;
            zero      <= (shifted == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        MUL: begin
          work   <= mul_sum;
          mcand  <= {mcand[XLEN-2:0], 1'b0};
          mplier <= {1'b0, mplier[XLEN-1:1]};
          cnt    <= cnt - 1'b1;
          if (cnt == 1) begin
            result    <= mul_sum;
            zero      <= (mul_sum == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed vector table, corner-case sequences and
// randomized ops checked against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  aluOp = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, illegal;

  int n_checks = 0;
  int n_fail = 0;

  alu_multicycle #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct3(funct3), .funct7_5(funct7_5),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result straight from the ISA arithmetic; latency in edges after accept.
  function automatic void ref_model(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic ill, output int lat);
    int sh;
    logic signed [31:0] sa, sb;
    longint unsigned prod;
    sh = int'(b % 32);
    sa = a; sb = b;
    ill = 1'b0; lat = 0; res = 32'h0;
    if (op == 2'b00) res = a + b;
    else if (op == 2'b01) res = a - b;
    else if (op == 2'b11) begin
      if (f3 == 3'd0) begin
        prod = longint'(a) * longint'(b);
        res = prod[31:0];
        lat = 32;
      end else ill = 1'b1;
    end else begin
      case (f3)
        3'd0: res = f75 ? a - b : a + b;
        3'd1: begin res = a << sh; lat = sh; end
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: begin res = f75 ? 32'(sa >>> sh) : (a >> sh); lat = sh; end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
  endfunction

  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic f75, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic eill, input int elat,
                        input int hold);
    int e;
    logic [31:0] r0;
    @(negedge clk);
    check({name, " in_ready_before"}, in_ready, 1);
    aluOp = op; funct3 = f3; funct7_5 = f75; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    aluOp = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
    op_a = $urandom; op_b = $urandom;
    e = 0;
    @(negedge clk);
    while (!out_valid && e < 100) begin
      @(negedge clk);
      e++;
    end
    check({name, " latency"}, e, elat);
    check({name, " result"}, result, eres);
    check({name, " zero"}, zero, (eres == 32'h0));
    check({name, " illegal"}, illegal, eill);
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " held_valid"}, out_valid, 1);
      check({name, " held_result"}, result, r0);
      check({name, " held_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, " released_valid"}, out_valid, 0);
    check({name, " released_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] r;
    logic ill;
    int lat;
    logic [1:0] op;
    logic [2:0] f3;
    logic f75;
    logic [31:0] a, b;

    vecs[0]  = '{2'b00, 3'd0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 0};
    vecs[1]  = '{2'b01, 3'd0, 1'b0, 32'd9,        32'd9,        32'd0,        1'b0, 0};
    vecs[2]  = '{2'b10, 3'd5, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 4};
    vecs[3]  = '{2'b10, 3'd5, 1'b1, 32'h80000000, 32'h20,       32'h80000000, 1'b0, 0};
    vecs[4]  = '{2'b11, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 1'b0, 32};
    vecs[5]  = '{2'b11, 3'd2, 1'b0, 32'h1234,     32'h5678,     32'h0,        1'b1, 0};
    vecs[6]  = '{2'b10, 3'd3, 1'b0, 32'd1,        32'd2,        32'd1,        1'b0, 0};
    vecs[7]  = '{2'b10, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 0};
    vecs[8]  = '{2'b10, 3'd3, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 0};
    vecs[9]  = '{2'b10, 3'd1, 1'b0, 32'h00000003, 32'hFFFFFFE1, 32'h00000006, 1'b0, 1};
    vecs[10] = '{2'b10, 3'd5, 1'b0, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 31};
    vecs[11] = '{2'b10, 3'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 0};
    vecs[12] = '{2'b10, 3'd6, 1'b0, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 0};
    vecs[13] = '{2'b10, 3'd7, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 0};
    vecs[14] = '{2'b10, 3'd0, 1'b1, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 0};
    vecs[15] = '{2'b00, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 0};

    #23;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 0);
    check("reset zero", zero, 0);
    check("reset illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].f75, vecs[i].a,
             vecs[i].b, vecs[i].res, vecs[i].ill, vecs[i].lat, (i == 4) ? 5 : 0);

    // Leave a nonzero result registered, then reset 10 cycles into a MUL.
    run_op("pre_rst", 2'b00, 3'd0, 1'b0, 32'd40, 32'd2, 32'd42, 1'b0, 0, 0);
    @(negedge clk);
    aluOp = 2'b11; funct3 = 3'd0; op_a = 32'h1234567; op_b = 32'h89ABCDE; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst result", result, 0);
    check("midrst zero", zero, 0);
    check("midrst illegal", illegal, 0);
    check("midrst in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_sltu", 2'b10, 3'd3, 1'b0, 32'd1, 32'd2, 32'd1, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom); f3 = 3'($urandom); f75 = 1'($urandom);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000001F;
      if ($urandom_range(0, 5) == 0) a = b;
      ref_model(op, f3, f75, a, b, r, ill, lat);
      run_op($sformatf("rnd%0d", i), op, f3, f75, a, b, r, ill, lat, $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
